// File: rtl/hidden_bp_pkg.sv
// Shared types and default constants for the hidden-neuron backprop weight updater.
package hidden_bp_pkg;

    localparam int W_WIDTH_DEF  = 8;
    localparam int LR_SHIFT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_UPDATE,
        ST_DONE
    } bp_state_e;

    typedef logic signed [W_WIDTH_DEF-1:0] weight_t;

endpackage

// File: rtl/hidden_bp_sat_add.sv
// W-bit signed adder; saturates to the signed range when HIDDEN_BP_SAT_EN is defined,
// otherwise wraps modulo 2^W.
module hidden_bp_sat_add #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum
);

`ifdef HIDDEN_BP_SAT_EN
    logic [W:0] wide;

    // One guard bit: overflow shows up as the two top bits disagreeing.
    assign wide = {a[W-1], a} + {b[W-1], b};

    always_comb begin
        sum = wide[W-1:0];
        if (wide[W] != wide[W-1]) begin
            sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/hidden_backprop_seq.sv
// Sequential weight updater for one hidden neuron: w_k += x[k] ? (err >>> LR_SHIFT) : 0,
// one weight per cycle. Define HIDDEN_BP_SAT_EN for saturating adds (default: wrap).
module hidden_backprop_seq
    import hidden_bp_pkg::*;
#(
    parameter int N_IN     = 4,
    parameter int W_WIDTH  = W_WIDTH_DEF,
    parameter int LR_SHIFT = LR_SHIFT_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic                      start_i,
    input  logic signed [W_WIDTH-1:0] err_i,
    input  logic [N_IN-1:0]           x_i,
    input  logic [N_IN*W_WIDTH-1:0]   w_i,
    output logic [N_IN*W_WIDTH-1:0]   w_o,
    output logic                      busy_o,
    output logic                      valid_o
);

    localparam int K_W = $clog2(N_IN);
    localparam logic [K_W-1:0] K_LAST = K_W'(N_IN - 1);

    bp_state_e                       state;
    logic signed [W_WIDTH-1:0]       err_q;
    logic signed [W_WIDTH-1:0]       delta_q;
    logic [N_IN-1:0]                 x_q;
    logic [N_IN-1:0][W_WIDTH-1:0]    w_work;
    logic [N_IN-1:0][W_WIDTH-1:0]    w_out_q;
    logic [K_W-1:0]                  k;

    logic signed [W_WIDTH-1:0]       addend;
    logic signed [W_WIDTH-1:0]       w_next;

    // Gated delta for the weight currently addressed by k.
    assign addend = x_q[k] ? delta_q : '0;

    hidden_bp_sat_add #(
        .W (W_WIDTH)
    ) u_add (
        .a   (w_work[k]),
        .b   (addend),
        .sum (w_next)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: every datapath register is cleared here, not just the FSM, so a reset
            // mid-update leaves no stale operands and w_o reads zero immediately.
            state   <= ST_IDLE;
            err_q   <= '0;
            delta_q <= '0;
            x_q     <= '0;
            w_work  <= '0;
            w_out_q <= '0;
            k       <= '0;
            valid_o <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; valid_o defaults low so it can only pulse.
            valid_o <= 1'b0;
            if (state != ST_IDLE && !en_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i && en_i) begin
                            err_q  <= err_i;
                            x_q    <= x_i;
                            w_work <= w_i;
                            state  <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        delta_q <= err_q >>> LR_SHIFT;
                        k       <= '0;
                        state   <= ST_UPDATE;
                    end
                    ST_UPDATE: begin
                        w_work[k] <= w_next;
                        if (k == K_LAST) begin
                            state <= ST_DONE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        w_out_q <= w_work;
                        valid_o <= 1'b1;
                        state   <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy_o = (state != ST_IDLE);
    assign w_o    = w_out_q;

endmodule

// File: tb/tb_hidden_backprop_seq.sv
// Directed self-checking bench for hidden_backprop_seq (N_IN=4, W_WIDTH=8, LR_SHIFT=2).
// Expected overflow results follow HIDDEN_BP_SAT_EN when it is defined.
module tb_hidden_backprop_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en_i;
    logic        start_i;
    logic [7:0]  err_i;
    logic [3:0]  x_i;
    logic [31:0] w_i;
    logic [31:0] w_o;
    logic        busy_o;
    logic        valid_o;

    int n_checks = 0;
    int n_errors = 0;

    hidden_backprop_seq #(
        .N_IN     (4),
        .W_WIDTH  (8),
        .LR_SHIFT (2)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (en_i),
        .start_i (start_i),
        .err_i   (err_i),
        .x_i     (x_i),
        .w_i     (w_i),
        .w_o     (w_o),
        .busy_o  (busy_o),
        .valid_o (valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one start and wait (bounded) for valid_o; lat counts edges after the start edge.
    task automatic run_update(input logic [7:0] err, input logic [3:0] x, input logic [31:0] w,
                              output int lat);
        @(negedge clk_i);
        err_i   = err;
        x_i     = x;
        w_i     = w;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check("busy_after_start", {31'd0, busy_o}, 32'd1);
        lat = 0;
        while (!valid_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        check("busy_low_at_valid", {31'd0, busy_o}, 32'd0);
        @(posedge clk_i);
        #1;
        check("valid_one_cycle", {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [31:0] exp_w;

        rst_ni  = 1'b0;
        en_i    = 1'b1;
        start_i = 1'b0;
        err_i   = '0;
        x_i     = '0;
        w_i     = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_w_o", w_o, 32'd0);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_valid", {31'd0, valid_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Basic: w=[10,20,30,40], x=0101, err=16 -> delta 4 -> [14,20,34,40]
        run_update(8'd16, 4'b0101, 32'h281E140A, lat);
        check("basic_latency", lat, 32'd6);
        check("basic_w_o", w_o, 32'h2822140E);

        // All inputs active, err=-5 -> delta floor(-1.25)=-2: [1,2,3,4] -> [-1,0,1,2]
        run_update(8'hFB, 4'b1111, 32'h04030201, lat);
        check("floor_all_latency", lat, 32'd6);
        check("floor_all_w_o", w_o, 32'h020100FF);

        // Positive overflow: 120 + 16
`ifdef HIDDEN_BP_SAT_EN
        exp_w = 32'h0000007F;
`else
        exp_w = 32'h00000088;
`endif
        run_update(8'd64, 4'b0001, 32'h00000078, lat);
        check("pos_ovf_w_o", w_o, exp_w);

        // Negative overflow: -126 + (-8)
`ifdef HIDDEN_BP_SAT_EN
        exp_w = 32'h00000080;
`else
        exp_w = 32'h0000007A;
`endif
        run_update(8'hE0, 4'b0001, 32'h00000082, lat);
        check("neg_ovf_w_o", w_o, exp_w);

        // err=-1 -> delta=-1: -126 -> -127; gated-off weights pass through
        run_update(8'hFF, 4'b0001, 32'h55AA3382, lat);
        check("floor_m1_w_o", w_o, 32'h55AA3381);

        // Abort: drop en_i in UPDATE; w_o holds the previous result
        @(negedge clk_i);
        err_i   = 8'd40;
        x_i     = 4'b1111;
        w_i     = 32'h01010101;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        en_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (valid_o) pulses++;
            @(posedge clk_i);
            #1;
        end
        check("abort_no_valid", pulses, 32'd0);
        check("abort_w_o_held", w_o, 32'h55AA3381);
        @(negedge clk_i);
        en_i = 1'b1;

        // Second start during UPDATE is ignored
        @(negedge clk_i);
        err_i   = 8'd16;
        x_i     = 4'b0101;
        w_i     = 32'h281E140A;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        pulses  = 0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk_i);
            #1;
            if (i == 2) begin
                err_i   = 8'd100;
                x_i     = 4'b1111;
                w_i     = 32'h00000000;
                start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            if (valid_o) pulses++;
        end
        check("busy_start_pulses", pulses, 32'd1);
        check("busy_start_w_o", w_o, 32'h2822140E);

        // Reset during UPDATE
        @(negedge clk_i);
        err_i   = 8'd8;
        x_i     = 4'b1111;
        w_i     = 32'h11111111;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("midreset_w_o", w_o, 32'd0);
        check("midreset_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_update(8'd16, 4'b0101, 32'h281E140A, lat);
        check("post_reset_latency", lat, 32'd6);
        check("post_reset_w_o", w_o, 32'h2822140E);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
